// File: rtl/servo_pwm_gen_pkg.sv
// servo_pwm_gen_pkg
//   Shared servo constants and the ramp-state encoding used by the gimbal
//   servo PWM generator and its helpers.
//   Contents:
//     SERVO_PERIOD_TICKS, SERVO_MIN_W, SERVO_MAX_W, SERVO_CENTER_W, SERVO_STEP
//       default servo timing, in ticks
//     SERVO_W       default width of counter / width fields
//     ramp_state_t  HOLD=0, RAMP_UP=1, RAMP_DN=2
package servo_pwm_gen_pkg;

    localparam int SERVO_PERIOD_TICKS = 20000;
    localparam int SERVO_MIN_W        = 500;
    localparam int SERVO_MAX_W        = 2500;
    localparam int SERVO_CENTER_W     = 1500;
    localparam int SERVO_STEP         = 4;
    localparam int SERVO_W            = $clog2(SERVO_PERIOD_TICKS + 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if
//   Target-width handshake between the tracking controller and the servo
//   PWM generator.
//   Signals:
//     tgt_valid  controller offers a new target width
//     tgt_ready  generator's one-entry pending slot is empty
//     tgt_width  requested pulse width in ticks (W bits)
//   Modports:
//     master  tracking controller side
//     slave   servo_pwm_gen side
interface servo_pwm_gen_if #(
    parameter int W = servo_pwm_gen_pkg::SERVO_W
);

    logic         tgt_valid;
    logic         tgt_ready;
    logic [W-1:0] tgt_width;

    modport master (
        output tgt_valid,
        output tgt_width,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_width,
        output tgt_ready
    );

endinterface

// File: rtl/servo_ramp_step.sv
// servo_ramp_step
//   Combinational saturating step: moves cur toward tgt by at most STEP,
//   never overshooting. STEP=0 jumps straight to tgt.
//   Ports:
//     cur   in,  W  present pulse width
//     tgt   in,  W  width being approached
//     next  out, W  width after one step
module servo_ramp_step
    import servo_pwm_gen_pkg::*;
#(
    parameter int W    = SERVO_W,
    parameter int STEP = SERVO_STEP
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] next
);

    localparam logic signed [W:0] STEP_S = (W+1)'(STEP);
    localparam logic [W-1:0]      STEP_U = W'(STEP);

    // One extra bit keeps the signed difference exact over the full range.
    logic signed [W:0] diff;

    always_comb begin
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        next = tgt;
        if (STEP != 0) begin
            // Inside one step of the target the step lands exactly on it.
            if (diff > STEP_S) begin
                next = cur + STEP_U;
            end else if (diff < -STEP_S) begin
                next = cur - STEP_U;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Gimbal servo PWM generator. Uses the upstream tick counter's one-clock
//   enable as its time base, accepts clamped target widths through a
//   one-entry pending slot, ramps the live width toward the active target
//   by at most STEP ticks per period and drives a registered PWM output.
//   Ports:
//     clk           in   clock
//     reset_asyn    in   asynchronous active-high reset
//     tick_en       in   time-base pulse, one clock wide
//     tgt           slave handshake (tgt_valid / tgt_ready / tgt_width)
//     pwm_out       out  servo drive, registered
//     cur_width     out  live pulse width
//     period_start  out  high on the boundary clock
//     at_target     out  live width equals the active target
//     clamped       out  one-clock pulse after an out-of-range accept
module servo_pwm_gen
    import servo_pwm_gen_pkg::*;
#(
    parameter int PERIOD_TICKS = SERVO_PERIOD_TICKS,
    parameter int MIN_W        = SERVO_MIN_W,
    parameter int MAX_W        = SERVO_MAX_W,
    parameter int CENTER_W     = SERVO_CENTER_W,
    parameter int STEP         = SERVO_STEP,
    parameter int W            = $clog2(PERIOD_TICKS + 1)
) (
    input  logic          clk,
    input  logic          reset_asyn,
    input  logic          tick_en,
    servo_pwm_gen_if.slave tgt,
    output logic          pwm_out,
    output logic [W-1:0]  cur_width,
    output logic          period_start,
    output logic          at_target,
    output logic          clamped
);

    localparam logic [W-1:0] LAST_CNT = W'(PERIOD_TICKS - 1);
    localparam logic [W-1:0] MIN_V    = W'(MIN_W);
    localparam logic [W-1:0] MAX_V    = W'(MAX_W);
    localparam logic [W-1:0] CENTER_V = W'(CENTER_W);

    logic [W-1:0] cnt;
    logic [W-1:0] active_tgt;
    logic [W-1:0] slot_val;
    logic         slot_full;
    logic [W-1:0] clamp_val;
    logic         out_of_range;
    logic [W-1:0] step_tgt;
    logic [W-1:0] step_next;
    logic         boundary;
    logic         accept;
    ramp_state_t  ramp_state;

    assign boundary      = tick_en && (cnt == LAST_CNT);
    assign tgt.tgt_ready = !slot_full;
    assign accept        = tgt.tgt_valid && !slot_full;
    assign period_start  = boundary;

    // A full slot at the boundary becomes the new active target in the
    // same edge, so the step is taken toward it rather than the old one.
    assign step_tgt = slot_full ? slot_val : active_tgt;

    // Clamp on the raw full-width request.
    always_comb begin
        clamp_val    = tgt.tgt_width;
        out_of_range = 1'b0;
        if (tgt.tgt_width < MIN_V) begin
            clamp_val    = MIN_V;
            out_of_range = 1'b1;
        end else if (tgt.tgt_width > MAX_V) begin
            clamp_val    = MAX_V;
            out_of_range = 1'b1;
        end
    end

    servo_ramp_step #(
        .W    (W),
        .STEP (STEP)
    ) u_ramp_step (
        .cur  (cur_width),
        .tgt  (step_tgt),
        .next (step_next)
    );

    always_ff @(posedge clk or posedge reset_asyn) begin
        if (reset_asyn) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    // Accept can only happen with the slot empty, so it never collides
    // with the boundary draining a full slot.
    always_ff @(posedge clk or posedge reset_asyn) begin
        if (reset_asyn) begin
            cur_width  <= CENTER_V;
            active_tgt <= CENTER_V;
            slot_full  <= 1'b0;
            slot_val   <= '0;
        end else begin
            if (boundary) begin
                cur_width <= step_next;
                if (slot_full) begin
                    active_tgt <= slot_val;
                    slot_full  <= 1'b0;
                end
            end
            if (accept) begin
                slot_full <= 1'b1;
                slot_val  <= clamp_val;
            end
        end
    end

    // Width 0 never satisfies cnt < width and width PERIOD_TICKS always
    // does, which gives the constant-low / constant-high extremes.
    always_ff @(posedge clk or posedge reset_asyn) begin
        if (reset_asyn) begin
            pwm_out <= 1'b0;
            clamped <= 1'b0;
        end else begin
            pwm_out <= (cnt < cur_width);
            clamped <= accept && out_of_range;
        end
    end

    always_comb begin
        ramp_state = HOLD;
        if (cur_width < active_tgt) begin
            ramp_state = RAMP_UP;
        end else if (cur_width > active_tgt) begin
            ramp_state = RAMP_DN;
        end
    end

    assign at_target = (ramp_state == HOLD);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen
//   Self-checking bench for servo_pwm_gen with a small period (20 ticks),
//   tick_en every 4th clock, directed scenarios plus a randomized run
//   compared against a behavioural model of periods, pending slot and ramp.
module tb_servo_pwm_gen;

    localparam int P         = 20;
    localparam int MIN_W_TB  = 2;
    localparam int MAX_W_TB  = 18;
    localparam int CENTER_TB = 10;
    localparam int STEP_TB   = 3;
    localparam int W         = $clog2(P + 1);

    logic         clk = 1'b0;
    logic         reset_asyn;
    logic         tick_en;
    logic         pwm_out;
    logic [W-1:0] cur_width;
    logic         period_start;
    logic         at_target;
    logic         clamped;

    servo_pwm_gen_if #(.W(W)) tgt_bus ();

    servo_pwm_gen #(
        .PERIOD_TICKS (P),
        .MIN_W        (MIN_W_TB),
        .MAX_W        (MAX_W_TB),
        .CENTER_W     (CENTER_TB),
        .STEP         (STEP_TB),
        .W            (W)
    ) dut (
        .clk          (clk),
        .reset_asyn   (reset_asyn),
        .tick_en      (tick_en),
        .tgt          (tgt_bus),
        .pwm_out      (pwm_out),
        .cur_width    (cur_width),
        .period_start (period_start),
        .at_target    (at_target),
        .clamped      (clamped)
    );

    always #5 clk = ~clk;

    // Behavioural model: tick position in the period, live and active widths,
    // and the pending slot as a queue.
    int  m_cnt;
    int  m_cur;
    int  m_act;
    int  pend[$];
    bit  m_pwm;
    bit  m_clamped;
    bit  m_ready;
    bit  m_ps;
    bit  m_at;
    int  cyc;
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic int clamp_w(input int raw);
        if (raw < MIN_W_TB) return MIN_W_TB;
        if (raw > MAX_W_TB) return MAX_W_TB;
        return raw;
    endfunction

    function automatic int move_toward(input int cur, input int tgt);
        int d = tgt - cur;
        if (STEP_TB == 0) return tgt;
        if (d > STEP_TB) return cur + STEP_TB;
        if (d < -STEP_TB) return cur - STEP_TB;
        return tgt;
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_cur     = CENTER_TB;
        m_act     = CENTER_TB;
        pend.delete();
        m_pwm     = 1'b0;
        m_clamped = 1'b0;
        m_ready   = 1'b1;
        m_ps      = 1'b0;
        m_at      = 1'b1;
        cyc       = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_asyn        = 1'b1;
        tick_en           = 1'b0;
        tgt_bus.tgt_valid = 1'b0;
        tgt_bus.tgt_width = '0;
        model_reset();
        @(negedge clk);
        reset_asyn = 1'b0;
    endtask

    // Drive this clock's inputs and work out what the model expects before the edge.
    task automatic set_inputs(input bit v, input int w);
        tgt_bus.tgt_valid = v;
        tgt_bus.tgt_width = W'(w);
        tick_en           = ((cyc % 4) == 3);
        #1;
        m_ready = (pend.size() == 0);
        m_ps    = tick_en && (m_cnt == P - 1);
        m_at    = (m_cur == m_act);
    endtask

    // Take the edge and advance the model by one clock.
    task automatic clock_edge();
        bit acc;
        bit bnd;
        bit next_pwm;
        int raw;
        acc = tgt_bus.tgt_valid && m_ready;
        bnd = m_ps;
        raw = int'(tgt_bus.tgt_width);
        @(posedge clk);
        next_pwm = (m_cnt < m_cur);
        if (bnd) begin
            if (pend.size() != 0) m_act = pend.pop_front();
            m_cur = move_toward(m_cur, m_act);
        end
        m_clamped = acc && ((raw < MIN_W_TB) || (raw > MAX_W_TB));
        if (acc) pend.push_back(clamp_w(raw));
        if (tick_en) m_cnt = (m_cnt + 1) % P;
        m_pwm   = next_pwm;
        m_ready = (pend.size() == 0);
        m_at    = (m_cur == m_act);
        cyc++;
        #1;
    endtask

    // Runs until the DUT flags a boundary and that edge has been taken.
    task automatic run_to_boundary(input bit v, input int w, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            set_inputs(v, w);
            hit = (period_start === 1'b1);
            clock_edge();
        end
    endtask

    task automatic test_reset();
        int highs  = 0;
        int starts = 0;
        int first  = -1;
        int second = -1;
        int at_bad = 0;
        n_checks++; if (cur_width !== W'(CENTER_TB)) begin n_fail++; $display("[TB] FAIL reset_cur_width: got %0d, expected %0d", cur_width, CENTER_TB); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm_out: got %0b, expected 0", pwm_out); end
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_period_start: got %0b, expected 0", period_start); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_at_target: got %0b, expected 1", at_target); end
        n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clamped: got %0b, expected 0", clamped); end
        n_checks++; if (tgt_bus.tgt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tgt_ready: got %0b, expected 1", tgt_bus.tgt_ready); end
        for (int i = 0; i < 2 * 4 * P; i++) begin
            set_inputs(1'b0, 0);
            if (period_start === 1'b1) begin
                starts++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            clock_edge();
            if (i < 4 * P && pwm_out === 1'b1) highs++;
            if (at_target !== 1'b1) at_bad++;
        end
        n_checks++; if (highs != 4 * CENTER_TB) begin n_fail++; $display("[TB] FAIL idle_pwm_high_clocks: got %0d, expected %0d", highs, 4 * CENTER_TB); end
        n_checks++; if (starts != 2) begin n_fail++; $display("[TB] FAIL idle_period_start_count: got %0d, expected 2", starts); end
        n_checks++; if (second - first != 4 * P) begin n_fail++; $display("[TB] FAIL idle_period_spacing: got %0d, expected %0d", second - first, 4 * P); end
        n_checks++; if (at_bad != 0) begin n_fail++; $display("[TB] FAIL idle_at_target_drops: got %0d, expected 0", at_bad); end
    endtask

    task automatic test_ramp_up();
        bit hit;
        apply_reset();
        set_inputs(1'b1, 16);
        clock_edge();
        n_checks++; if (tgt_bus.tgt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_ready_after_accept: got %0b, expected 0", tgt_bus.tgt_ready); end
        n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_no_clamp: got %0b, expected 0", clamped); end
        run_to_boundary(1'b0, 0, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL ramp_boundary1_timeout: got 0, expected 1"); end
        n_checks++; if (cur_width !== W'(13)) begin n_fail++; $display("[TB] FAIL ramp_b1_width: got %0d, expected 13", cur_width); end
        n_checks++; if (at_target !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_b1_at_target: got %0b, expected 0", at_target); end
        run_to_boundary(1'b0, 0, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL ramp_boundary2_timeout: got 0, expected 1"); end
        n_checks++; if (cur_width !== W'(16)) begin n_fail++; $display("[TB] FAIL ramp_b2_width: got %0d, expected 16", cur_width); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("[TB] FAIL ramp_b2_at_target: got %0b, expected 1", at_target); end
    endtask

    task automatic test_clamp_low();
        bit hit;
        int exp_w[4] = '{7, 4, 2, 2};
        apply_reset();
        set_inputs(1'b1, 0);
        clock_edge();
        n_checks++; if (clamped !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_pulse: got %0b, expected 1", clamped); end
        set_inputs(1'b0, 0);
        clock_edge();
        n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("[TB] FAIL clamp_pulse_width: got %0b, expected 0", clamped); end
        for (int k = 0; k < 4; k++) begin
            run_to_boundary(1'b0, 0, 100, hit);
            n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL clamp_boundary_timeout: boundary %0d got 0, expected 1", k + 1); end
            n_checks++; if (cur_width !== W'(exp_w[k])) begin n_fail++; $display("[TB] FAIL clamp_width: boundary %0d got %0d, expected %0d", k + 1, cur_width, exp_w[k]); end
        end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("[TB] FAIL clamp_at_target: got %0b, expected 1", at_target); end
    endtask

    task automatic test_slot_full();
        bit hit = 1'b0;
        int ready_bad = 0;
        int exp_w[3] = '{10, 7, 6};
        apply_reset();
        set_inputs(1'b1, 14);
        clock_edge();
        for (int i = 0; i < 100 && !hit; i++) begin
            set_inputs(1'b1, 6);
            if (tgt_bus.tgt_ready !== 1'b0) ready_bad++;
            hit = (period_start === 1'b1);
            clock_edge();
        end
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL slot_boundary1_timeout: got 0, expected 1"); end
        n_checks++; if (ready_bad != 0) begin n_fail++; $display("[TB] FAIL slot_ready_while_full: got %0d high clocks, expected 0", ready_bad); end
        n_checks++; if (cur_width !== W'(13)) begin n_fail++; $display("[TB] FAIL slot_b1_width: got %0d, expected 13", cur_width); end
        n_checks++; if (tgt_bus.tgt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL slot_ready_after_boundary: got %0b, expected 1", tgt_bus.tgt_ready); end
        set_inputs(1'b1, 6);
        clock_edge();
        n_checks++; if (tgt_bus.tgt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL slot_second_accept: got %0b, expected 0", tgt_bus.tgt_ready); end
        for (int k = 0; k < 3; k++) begin
            run_to_boundary(1'b0, 0, 100, hit);
            n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL slot_boundary_timeout: boundary %0d got 0, expected 1", k + 2); end
            n_checks++; if (cur_width !== W'(exp_w[k])) begin n_fail++; $display("[TB] FAIL slot_width: boundary %0d got %0d, expected %0d", k + 2, cur_width, exp_w[k]); end
        end
    endtask

    task automatic test_boundary_accept();
        bit hit;
        apply_reset();
        for (int i = 0; i < 4 * P - 1; i++) begin
            set_inputs(1'b0, 0);
            clock_edge();
        end
        set_inputs(1'b1, 12);
        n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("[TB] FAIL bacc_period_start: got %0b, expected 1", period_start); end
        n_checks++; if (tgt_bus.tgt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bacc_ready: got %0b, expected 1", tgt_bus.tgt_ready); end
        clock_edge();
        n_checks++; if (cur_width !== W'(CENTER_TB)) begin n_fail++; $display("[TB] FAIL bacc_no_bypass: got %0d, expected %0d", cur_width, CENTER_TB); end
        n_checks++; if (tgt_bus.tgt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bacc_slot_taken: got %0b, expected 0", tgt_bus.tgt_ready); end
        run_to_boundary(1'b0, 0, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL bacc_boundary_timeout: got 0, expected 1"); end
        n_checks++; if (cur_width !== W'(12)) begin n_fail++; $display("[TB] FAIL bacc_next_width: got %0d, expected 12", cur_width); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("[TB] FAIL bacc_at_target: got %0b, expected 1", at_target); end
    endtask

    task automatic test_reset_mid_ramp();
        bit hit;
        apply_reset();
        set_inputs(1'b1, 16);
        clock_edge();
        run_to_boundary(1'b0, 0, 100, hit);
        n_checks++; if (cur_width !== W'(13)) begin n_fail++; $display("[TB] FAIL mid_pre_width: got %0d, expected 13", cur_width); end
        set_inputs(1'b1, 4);
        clock_edge();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b0, 0);
            clock_edge();
        end
        n_checks++; if (pwm_out !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_pwm: got %0b, expected 1", pwm_out); end
        #2;
        reset_asyn = 1'b1;
        tick_en    = 1'b0;
        #1;
        n_checks++; if (cur_width !== W'(CENTER_TB)) begin n_fail++; $display("[TB] FAIL mid_reset_width: got %0d, expected %0d", cur_width, CENTER_TB); end
        n_checks++; if (tgt_bus.tgt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_ready: got %0b, expected 1", tgt_bus.tgt_ready); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_pwm: got %0b, expected 0", pwm_out); end
        n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_at_target: got %0b, expected 1", at_target); end
        n_checks++; if (clamped !== 1'b0 || period_start !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_pulses: got %0b%0b, expected 00", clamped, period_start); end
        model_reset();
        @(negedge clk);
        reset_asyn = 1'b0;
        run_to_boundary(1'b0, 0, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL mid_boundary_timeout: got 0, expected 1"); end
        n_checks++; if (cur_width !== W'(CENTER_TB)) begin n_fail++; $display("[TB] FAIL mid_pending_discarded: got %0d, expected %0d", cur_width, CENTER_TB); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 2400; i++) begin
            bit v;
            int w;
            v = ($urandom_range(0, 3) == 0);
            w = $urandom_range(0, (1 << W) - 1);
            set_inputs(v, w);
            n_checks++; if (tgt_bus.tgt_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rnd_ready: cyc %0d got %0b, expected %0b", cyc, tgt_bus.tgt_ready, m_ready); end
            n_checks++; if (period_start !== m_ps) begin n_fail++; $display("[TB] FAIL rnd_period_start: cyc %0d got %0b, expected %0b", cyc, period_start, m_ps); end
            n_checks++; if (at_target !== m_at) begin n_fail++; $display("[TB] FAIL rnd_at_target: cyc %0d got %0b, expected %0b", cyc, at_target, m_at); end
            clock_edge();
            n_checks++; if (cur_width !== W'(m_cur)) begin n_fail++; $display("[TB] FAIL rnd_cur_width: cyc %0d got %0d, expected %0d", cyc, cur_width, m_cur); end
            n_checks++; if (pwm_out !== m_pwm) begin n_fail++; $display("[TB] FAIL rnd_pwm_out: cyc %0d got %0b, expected %0b", cyc, pwm_out, m_pwm); end
            n_checks++; if (clamped !== m_clamped) begin n_fail++; $display("[TB] FAIL rnd_clamped: cyc %0d got %0b, expected %0b", cyc, clamped, m_clamped); end
        end
    endtask

    initial begin
        reset_asyn        = 1'b1;
        tick_en           = 1'b0;
        tgt_bus.tgt_valid = 1'b0;
        tgt_bus.tgt_width = '0;
        apply_reset();
        $display("[TB] reset and idle period");
        test_reset();
        $display("[TB] ramp up");
        test_ramp_up();
        $display("[TB] clamp low");
        test_clamp_low();
        $display("[TB] slot full");
        test_slot_full();
        $display("[TB] accept on boundary clock");
        test_boundary_accept();
        $display("[TB] reset mid-ramp");
        test_reset_mid_ramp();
        $display("[TB] randomized run");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
